// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 8;

    // Sequencer states; encodings 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_e;

endpackage

// File: rtl/mult_bit_cnt.sv
// Iteration counter for the multiplier sequencer: synchronous clear,
// increment, and a terminal flag raised on the final iteration (WIDTH-1).
module mult_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt_reg;

    // Counter register; clear takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign last = (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencer for the signed shift-add multiplier datapath (A/B register pair
// plus adder). Loads B / clears A on request, runs WIDTH add/shift
// iterations with the last one subtracting, and holds Done until Run drops.
//
// Optional build macro MULT_CTRL_SKIP_ZERO_EN: zero multiplier bits cost a
// single shift cycle instead of an ADD+SHIFT pair. Since the post-shift
// multiplier bit is only visible the cycle after a shift, that decision is
// taken on entry to ADD: with M=0 the ADD cycle performs the shift itself
// (no Ld_A/Add/Sub) and advances the count, so the zero bit never spends a
// cycle adding. Latency then becomes 1 + WIDTH + popcount(B).
module mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Ld_A,
    output logic Ld_B,
    output logic Shift_En,
    output logic ResetA,
    output logic Add,
    output logic Sub,
    output logic Busy,
    output logic Done
);

    mult_state_e state_reg;
    mult_state_e state_next;

    logic cnt_clr;
    logic cnt_inc;
    logic cnt_last;

    logic ld_a_next;
    logic ld_b_next;
    logic shift_en_next;
    logic reset_a_next;
    logic add_next;
    logic sub_next;
    logic busy_next;
    logic done_next;

    mult_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    // State register; reset aborts any operation in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and output decode (IDLE outputs are Mealy on ClearA_LoadB).
    always_comb begin
        state_next    = state_reg;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        ld_a_next     = 1'b0;
        ld_b_next     = 1'b0;
        shift_en_next = 1'b0;
        reset_a_next  = 1'b0;
        add_next      = 1'b0;
        sub_next      = 1'b0;
        busy_next     = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Run) begin
                    state_next = CLR;
                end else if (ClearA_LoadB) begin
                    ld_b_next    = 1'b1;
                    reset_a_next = 1'b1;
                end
            end

            CLR: begin
                busy_next    = 1'b1;
                reset_a_next = 1'b1;
                cnt_clr      = 1'b1;
                state_next   = ADD;
            end

            ADD: begin
                busy_next = 1'b1;
`ifdef MULT_CTRL_SKIP_ZERO_EN
                if (!M) begin
                    // Zero bit: shift straight away, no add.
                    shift_en_next = 1'b1;
                    if (cnt_last) begin
                        state_next = HOLD;
                    end else begin
                        cnt_inc    = 1'b1;
                        state_next = ADD;
                    end
                end else begin
                    ld_a_next  = 1'b1;
                    add_next   = !cnt_last;
                    sub_next   = cnt_last;
                    state_next = SHIFT;
                end
`else
                ld_a_next  = M;
                add_next   = M & !cnt_last;
                sub_next   = M & cnt_last;
                state_next = SHIFT;
`endif
            end

            SHIFT: begin
                busy_next     = 1'b1;
                shift_en_next = 1'b1;
                if (cnt_last) begin
                    state_next = HOLD;
                end else begin
                    cnt_inc    = 1'b1;
                    state_next = ADD;
                end
            end

            HOLD: begin
                done_next = 1'b1;
                if (!Run) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is asserted, including the
    // Mealy IDLE outputs that would otherwise follow ClearA_LoadB.
    assign Ld_A     = Reset_n & ld_a_next;
    assign Ld_B     = Reset_n & ld_b_next;
    assign Shift_En = Reset_n & shift_en_next;
    assign ResetA   = Reset_n & reset_a_next;
    assign Add      = Reset_n & add_next;
    assign Sub      = Reset_n & sub_next;
    assign Busy     = Reset_n & busy_next;
    assign Done     = Reset_n & done_next;

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control with a small B-register model that
// feeds M back to the sequencer, and a scoreboard of per-operation pulse counts.
module tb_mult_control;

    logic clk = 1'b0;
    logic Reset_n;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Ld_A, Ld_B, Shift_En, ResetA, Add, Sub, Busy, Done;

    logic [7:0] sw = 8'h00;
    logic [7:0] b_model = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int busy;
        int adds;
        int subs;
        int lda;
        int shifts;
    } op_exp_t;

    op_exp_t exp_q[$];

    always #5 clk = ~clk;

    mult_control #(.WIDTH(8)) dut (
        .Clk          (clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Ld_A         (Ld_A),
        .Ld_B         (Ld_B),
        .Shift_En     (Shift_En),
        .ResetA       (ResetA),
        .Add          (Add),
        .Sub          (Sub),
        .Busy         (Busy),
        .Done         (Done)
    );

    // Multiplier register model: load from switches, shift right on Shift_En.
    always @(posedge clk) begin
        if (Ld_B) begin
            b_model <= sw;
        end else if (Shift_En) begin
            b_model <= {1'b0, b_model[7:1]};
        end
    end

    assign M = b_model[0];

    function automatic int outs();
        return int'({Ld_A, Ld_B, Shift_En, ResetA, Add, Sub, Busy, Done});
    endfunction

    function automatic int popcnt(input logic [7:0] v);
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(v[k]);
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] val);
        @(negedge clk);
        sw = val;
        ClearA_LoadB = 1'b1;
        #1 check("load_outputs", outs(), 8'b0101_0000);
        @(negedge clk);
        ClearA_LoadB = 1'b0;
    endtask

    // One full multiply: optional Run+ClearA_LoadB collision, run to Done,
    // hold Done, then release Run and confirm return to IDLE.
    task automatic run_op(input logic [7:0] val, input bit both);
        op_exp_t e;
        op_exp_t got;
        int ldb = 0;
        int viol = 0;
        bit seen = 1'b0;

        load_b(val);
`ifdef MULT_CTRL_SKIP_ZERO_EN
        e.busy = 1 + 8 + popcnt(val);
`else
        e.busy = 1 + 2 * 8;
`endif
        e.adds   = popcnt(val & 8'h7F);
        e.subs   = int'(val[7]);
        e.lda    = popcnt(val);
        e.shifts = 8;
        exp_q.push_back(e);

        if (both) begin
            sw = ~val;
            ClearA_LoadB = 1'b1;
        end
        Run = 1'b1;
        #1 check("ldb_when_run", int'(Ld_B), 0);

        got = '{default: 0};
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) check("clr_cycle", outs(), 8'b0001_0010);
            if (Done) begin
                seen = 1'b1;
                break;
            end
            got.busy   += int'(Busy);
            got.adds   += int'(Add);
            got.subs   += int'(Sub);
            got.lda    += int'(Ld_A);
            got.shifts += int'(Shift_En);
            ldb        += int'(Ld_B);
            if ((int'(Ld_A) + int'(Shift_En) + int'(ResetA)) > 1 || (Add && Sub)) viol++;
        end
        check("done_seen", int'(seen), 1);

        e = exp_q.pop_front();
        check("busy_cycles", got.busy, e.busy);
        check("add_pulses", got.adds, e.adds);
        check("sub_pulses", got.subs, e.subs);
        check("lda_pulses", got.lda, e.lda);
        check("shift_pulses", got.shifts, e.shifts);
        check("ldb_during_op", ldb, 0);
        check("exclusive", viol, 0);
        $display("op B=0x%02h both=%0d busy=%0d add=%0d sub=%0d lda=%0d shift=%0d",
                 val, both, got.busy, got.adds, got.subs, got.lda, got.shifts);

        repeat (2) begin
            @(negedge clk);
            check("done_hold", outs(), 8'b0000_0001);
        end
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        @(negedge clk);
        check("idle_after_release", outs(), 0);
    endtask

    initial begin
        int shifts;
        int stray;
        bit hit;

        // Reset with every input asserted: outputs must all be low.
        Reset_n = 1'b0;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 0);
        Run = 1'b0;
        #1 check("reset_outputs_clab", outs(), 0);
        Reset_n = 1'b1;
        #1 check("idle_clab_high", outs(), 8'b0101_0000);
        ClearA_LoadB = 1'b0;
        #1 check("idle_clab_low", outs(), 0);
        $display("reset and IDLE load decode done");

        run_op(8'hFF, 1'b0);
        run_op(8'h81, 1'b0);
        run_op(8'h00, 1'b0);
        run_op(8'h5A, 1'b1);
        for (int r = 0; r < 3; r++) run_op(8'($urandom_range(0, 255)), 1'b0);

        // Abort with reset at the third shift cycle.
        load_b(8'hFF);
        Run = 1'b1;
        shifts = 0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Shift_En) shifts++;
            if (shifts == 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("third_shift_reached", int'(hit), 1);
        Reset_n = 1'b0;
        #1 check("abort_outputs", outs(), 0);
        Run = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            stray += int'(Shift_En) + int'(Busy);
        end
        check("after_abort_idle", stray, 0);
        $display("reset abort at third shift done");

        // A full operation after the abort must start from a cleared count.
        run_op(8'hC3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
